// File: rtl/encdec_checker_gm.sv
// Clocked EncDec golden model: snoops APB writes into shadow registers and checks the DUT's
// error count on every operation_done rising edge. Optional macro APB_READ_CHECK_EN adds PRDATA checking.
module encdec_checker_gm #(
  parameter int unsigned AMBA_ADDR_WIDTH = 20,
  parameter int unsigned AMBA_WORD       = 32,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  input  logic [AMBA_WORD-1:0]       PRDATA,
  input  logic                       operation_done,
  input  logic [1:0]                 dut_num_of_errors,
  output logic [1:0]                 gm_number_of_errors,
  output logic                       check_valid,
  output logic                       mismatch,
  output logic                       rd_mismatch,
  output logic                       overrun,
  output logic [CNT_WIDTH-1:0]       check_count,
  output logic [CNT_WIDTH-1:0]       mismatch_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_REPORT
  } state_e;

  state_e                 state_q;
  logic [AMBA_WORD-1:0]   ctrl_q, data_in_q, cw_q, noise_q;
  logic                   done_d_q;
  logic [1:0]             ctrl_s_q, cw_s_q, dut_s_q;
  logic [AMBA_WORD-1:0]   noise_s_q;
  logic [1:0]             exp_q;
  logic [1:0]             gm_q;
  logic                   check_valid_q, mismatch_q, rd_mismatch_q, overrun_q;
  logic [CNT_WIDTH-1:0]   check_count_q, mismatch_count_q;

  logic                   wr_en, done_rise;
  logic [AMBA_WORD-1:0]   width_mask, masked_noise;
  logic [7:0]             pop_cnt;
  logic [1:0]             exp_d;
  logic                   chk_mis, rd_mis_d;
  logic [1:0]             mm_inc;
  logic [CNT_WIDTH:0]     mm_sum;
  logic [CNT_WIDTH-1:0]   mm_next, cc_next;
  logic                   unused_bits;

  assign wr_en     = PSEL & PENABLE & PWRITE;
  assign done_rise = operation_done & ~done_d_q;

  always_comb begin
    width_mask = '1;
    case (cw_s_q)
      2'b00:   width_mask = AMBA_WORD'(8'hFF);
      2'b01:   width_mask = AMBA_WORD'(16'hFFFF);
      2'b10:   width_mask = AMBA_WORD'(32'hFFFF_FFFF);
      default: width_mask = '1;
    endcase
  end

  assign masked_noise = noise_s_q & width_mask;
  assign pop_cnt      = 8'($countones(masked_noise));

  always_comb begin
    exp_d = 2'b00;
    if (ctrl_s_q != 2'b00) begin
      exp_d = (pop_cnt >= 8'd3) ? 2'b11 : pop_cnt[1:0];
    end
  end

`ifdef APB_READ_CHECK_EN
  logic [AMBA_WORD-1:0] rd_sel;
  always_comb begin
    rd_sel = ctrl_q;
    case (PADDR[3:2])
      2'b00:   rd_sel = ctrl_q;
      2'b01:   rd_sel = data_in_q;
      2'b10:   rd_sel = cw_q;
      default: rd_sel = noise_q;
    endcase
  end
  assign rd_mis_d = PSEL & PENABLE & ~PWRITE & (PRDATA != rd_sel);
`else
  assign rd_mis_d = 1'b0;
`endif

  assign unused_bits = ^{PADDR, PRDATA, data_in_q, ctrl_q, cw_q};

  assign chk_mis = (state_q == S_REPORT) && (dut_s_q != exp_q);

  // Check and read mismatches can land on the same edge, so the increment may be 2.
  assign mm_inc  = {1'b0, chk_mis} + {1'b0, rd_mis_d};
  assign mm_sum  = {1'b0, mismatch_count_q} + (CNT_WIDTH + 1)'(mm_inc);
  assign mm_next = mm_sum[CNT_WIDTH] ? '1 : mm_sum[CNT_WIDTH-1:0];
  assign cc_next = (&check_count_q) ? check_count_q : check_count_q + CNT_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= '0;
      data_in_q <= '0;
      cw_q      <= '0;
      noise_q   <= '0;
    end else if (wr_en) begin
      case (PADDR[3:2])
        2'b00:   ctrl_q    <= PWDATA;
        2'b01:   data_in_q <= PWDATA;
        2'b10:   cw_q      <= PWDATA;
        default: noise_q   <= PWDATA;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      done_d_q         <= 1'b1;
      ctrl_s_q         <= '0;
      cw_s_q           <= '0;
      dut_s_q          <= '0;
      noise_s_q        <= '0;
      exp_q            <= '0;
      gm_q             <= '0;
      check_valid_q    <= 1'b0;
      mismatch_q       <= 1'b0;
      rd_mismatch_q    <= 1'b0;
      overrun_q        <= 1'b0;
      check_count_q    <= '0;
      mismatch_count_q <= '0;
    end else begin
      done_d_q         <= operation_done;
      check_valid_q    <= 1'b0;
      mismatch_q       <= 1'b0;
      rd_mismatch_q    <= rd_mis_d;
      mismatch_count_q <= mm_next;
      case (state_q)
        S_IDLE: begin
          // Snapshot the pre-write shadow values; a same-edge APB write lands after this.
          if (done_rise) begin
            ctrl_s_q  <= ctrl_q[1:0];
            cw_s_q    <= cw_q[1:0];
            noise_s_q <= noise_q;
            dut_s_q   <= dut_num_of_errors;
            state_q   <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (done_rise) overrun_q <= 1'b1;
          exp_q   <= exp_d;
          state_q <= S_REPORT;
        end
        S_REPORT: begin
          if (done_rise) overrun_q <= 1'b1;
          check_valid_q <= 1'b1;
          mismatch_q    <= chk_mis;
          gm_q          <= exp_q;
          check_count_q <= cc_next;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gm_number_of_errors = gm_q;
  assign check_valid         = check_valid_q;
  assign mismatch            = mismatch_q;
  assign rd_mismatch         = rd_mismatch_q;
  assign overrun             = overrun_q;
  assign check_count         = check_count_q;
  assign mismatch_count      = mismatch_count_q;

endmodule

// File: tb/tb_encdec_checker_gm.sv
// Self-checking bench for encdec_checker_gm: directed and randomized checks against a
// specification-level model of the shadow registers, expected error count and counters.
module tb_encdec_checker_gm;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          operation_done;
  logic [1:0]    dut_num_of_errors;
  logic [1:0]    gm_number_of_errors;
  logic          check_valid, mismatch, rd_mismatch, overrun;
  logic [CW-1:0] check_count, mismatch_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_ctrl, m_data, m_cw, m_noise;
  int            m_checks, m_mm;

  encdec_checker_gm #(.AMBA_ADDR_WIDTH(AW), .AMBA_WORD(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .operation_done(operation_done), .dut_num_of_errors(dut_num_of_errors),
    .gm_number_of_errors(gm_number_of_errors), .check_valid(check_valid),
    .mismatch(mismatch), .rd_mismatch(rd_mismatch), .overrun(overrun),
    .check_count(check_count), .mismatch_count(mismatch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] model_exp(input logic [DW-1:0] ctrl, cw, noise);
    logic [DW-1:0] win;
    int            ones;
    if (ctrl[1:0] == 2'b00) return 2'b00;
    case (cw[1:0])
      2'b00:   win = noise % 256;
      2'b01:   win = noise % 65536;
      default: win = noise;
    endcase
    ones = $countones(win);
    return (ones >= 3) ? 2'd3 : 2'(ones);
  endfunction

  task automatic apb_write(input logic [1:0] reg_sel, input logic [DW-1:0] val);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = AW'({$urandom_range(0, 255), reg_sel, 2'b00}); PWDATA = val;
    @(negedge clk);
    PENABLE = 1'b1;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0;
    case (reg_sel)
      2'd0: m_ctrl = val;
      2'd1: m_data = val;
      2'd2: m_cw = val;
      default: m_noise = val;
    endcase
  endtask

  task automatic do_reset(input logic done_level);
    rst = 1'b1; operation_done = done_level;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0; PRDATA = '0;
    dut_num_of_errors = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_ctrl = '0; m_data = '0; m_cw = '0; m_noise = '0; m_checks = 0; m_mm = 0;
  endtask

  // done pulse, then verify timing, result and counters against the model
  task automatic run_check(input logic [1:0] dv, input string tag);
    logic [1:0] e;
    e = model_exp(m_ctrl, m_cw, m_noise);
    @(negedge clk);
    dut_num_of_errors = dv; operation_done = 1'b1;
    @(negedge clk);
    operation_done = 1'b0;
    checks++;
    if (check_valid !== 1'b0) begin errors++; $display("FAIL %s early_valid_c1 got %b want 0", tag, check_valid); end
    @(negedge clk);
    checks++;
    if (check_valid !== 1'b0) begin errors++; $display("FAIL %s early_valid_c2 got %b want 0", tag, check_valid); end
    @(negedge clk);
    m_checks++;
    if (dv != e) m_mm++;
    checks++;
    if (check_valid !== 1'b1) begin errors++; $display("FAIL %s valid got %b want 1", tag, check_valid); end
    checks++;
    if (gm_number_of_errors !== e) begin errors++; $display("FAIL %s gm got %b want %b", tag, gm_number_of_errors, e); end
    checks++;
    if (mismatch !== (dv != e)) begin errors++; $display("FAIL %s mismatch got %b want %b", tag, mismatch, dv != e); end
    checks++;
    if (check_count !== CW'(m_checks)) begin errors++; $display("FAIL %s check_count got %0d want %0d", tag, check_count, m_checks); end
    checks++;
    if (mismatch_count !== CW'(m_mm)) begin errors++; $display("FAIL %s mismatch_count got %0d want %0d", tag, mismatch_count, m_mm); end
    @(negedge clk);
    checks++;
    if (check_valid !== 1'b0 || gm_number_of_errors !== e) begin
      errors++; $display("FAIL %s hold valid=%b gm=%b want 0/%b", tag, check_valid, gm_number_of_errors, e);
    end
  endtask

  task automatic test_reset;
    do_reset(1'b1);
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (check_valid !== 1'b0) begin errors++; $display("FAIL reset_no_spurious valid got %b want 0", check_valid); end
    end
    checks++;
    if ({gm_number_of_errors, mismatch, rd_mismatch, overrun, check_count, mismatch_count} !== '0) begin
      errors++; $display("FAIL reset_outputs gm=%b mm=%b rd=%b ov=%b cc=%0d mc=%0d want all 0",
                         gm_number_of_errors, mismatch, rd_mismatch, overrun, check_count, mismatch_count);
    end
    operation_done = 1'b0;
  endtask

  task automatic test_directed;
    apb_write(2'd0, 32'd1); apb_write(2'd2, 32'd0); apb_write(2'd3, 32'h03);
    run_check(2'b10, "pop2");
    apb_write(2'd3, 32'h0100);
    run_check(2'b01, "mask8");
    apb_write(2'd0, 32'd0); apb_write(2'd3, 32'hFF);
    run_check(2'b00, "encode");
    apb_write(2'd0, 32'd2); apb_write(2'd2, 32'd2); apb_write(2'd3, 32'h7);
    run_check(2'b11, "pop3");
    apb_write(2'd2, 32'd1); apb_write(2'd3, 32'h0001_8000);
    run_check(2'b01, "mask16");
    apb_write(2'd2, 32'd3); apb_write(2'd3, 32'h8000_0000);
    run_check(2'b01, "mask_full");
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      apb_write(2'd0, $urandom());
      apb_write(2'd2, $urandom());
      apb_write(2'd3, (i % 2 == 0) ? ($urandom() & $urandom() & $urandom() & $urandom())
                                   : (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31)));
      run_check(2'($urandom_range(0, 3)), $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_overrun;
    logic [1:0] e;
    apb_write(2'd0, 32'd1); apb_write(2'd2, 32'd0); apb_write(2'd3, 32'h1);
    e = model_exp(m_ctrl, m_cw, m_noise);
    @(negedge clk);
    dut_num_of_errors = 2'b01; operation_done = 1'b1;
    @(negedge clk); operation_done = 1'b0;
    @(negedge clk); operation_done = 1'b1;
    @(negedge clk); operation_done = 1'b0;
    m_checks++;
    checks++;
    if (check_valid !== 1'b1 || gm_number_of_errors !== e) begin
      errors++; $display("FAIL overrun_first valid=%b gm=%b want 1/%b", check_valid, gm_number_of_errors, e);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b want 1", overrun); end
    checks++;
    if (check_count !== CW'(m_checks)) begin errors++; $display("FAIL overrun_count got %0d want %0d", check_count, m_checks); end
    run_check(2'b01, "after_overrun");
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b want 1", overrun); end
  endtask

  task automatic test_reset_mid;
    apb_write(2'd0, 32'd1); apb_write(2'd3, 32'h3);
    @(negedge clk);
    operation_done = 1'b1; dut_num_of_errors = 2'b00;
    @(negedge clk);
    operation_done = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ctrl = '0; m_data = '0; m_cw = '0; m_noise = '0; m_checks = 0; m_mm = 0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (check_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", check_valid); end
    end
    checks++;
    if (check_count !== '0 || mismatch_count !== '0 || overrun !== 1'b0) begin
      errors++; $display("FAIL rst_mid_counters cc=%0d mc=%0d ov=%b want 0/0/0", check_count, mismatch_count, overrun);
    end
  endtask

  task automatic test_prewrite;
    apb_write(2'd0, 32'd1); apb_write(2'd2, 32'd0); apb_write(2'd3, 32'd0);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = AW'(12); PWDATA = 32'h1;
    @(negedge clk);
    PENABLE = 1'b1; operation_done = 1'b1; dut_num_of_errors = 2'b00;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0; operation_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    m_checks++;
    checks++;
    if (check_valid !== 1'b1 || gm_number_of_errors !== 2'b00 || mismatch !== 1'b0) begin
      errors++; $display("FAIL prewrite valid=%b gm=%b mm=%b want 1/00/0", check_valid, gm_number_of_errors, mismatch);
    end
    m_noise = 32'h1;
    run_check(2'b01, "postwrite");
  endtask

  task automatic test_read_check;
    logic exp_rd;
`ifdef APB_READ_CHECK_EN
    exp_rd = 1'b1;
`else
    exp_rd = 1'b0;
`endif
    apb_write(2'd0, 32'h5); apb_write(2'd1, $urandom());
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = AW'(i * 4);
      case (i)
        0: PRDATA = m_ctrl ^ 32'h1;
        1: PRDATA = m_data;
        2: PRDATA = m_cw;
        default: PRDATA = m_noise ^ 32'h8000_0000;
      endcase
      @(negedge clk);
      PSEL = 1'b0; PENABLE = 1'b0;
      if ((i == 0 || i == 3) && exp_rd) m_mm++;
      checks++;
      if (rd_mismatch !== ((i == 0 || i == 3) && exp_rd)) begin
        errors++; $display("FAIL read%0d rd_mismatch got %b want %b", i, rd_mismatch, (i == 0 || i == 3) && exp_rd);
      end
      checks++;
      if (mismatch_count !== CW'(m_mm)) begin
        errors++; $display("FAIL read%0d mismatch_count got %0d want %0d", i, mismatch_count, m_mm);
      end
      @(negedge clk);
      checks++;
      if (rd_mismatch !== 1'b0) begin errors++; $display("FAIL read%0d rd_pulse got %b want 0", i, rd_mismatch); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_overrun();
    test_reset_mid();
    test_prewrite();
    test_read_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
